// File: rtl/mau_pkg.sv
// Shared constants for the memory access unit: access sizes, FSM states
// and the mask that turns a byte address into a word address.
package mau_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } mau_state_t;

endpackage

// File: rtl/mau_lane.sv
// Byte-lane logic: merges right-aligned store data into a memory word and
// extracts/extends load data from a memory word, both by address lane.
module mau_lane
    import mau_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] st_word,
    output logic [31:0] ld_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane select, merge and extension for the current size
    always_comb begin
        st_word  = word;
        ld_word  = word;
        sel_byte = word[7:0];
        sel_half = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0: st_word[7:0]   = wdata[7:0];
                    2'd1: st_word[15:8]  = wdata[7:0];
                    2'd2: st_word[23:16] = wdata[7:0];
                    2'd3: st_word[31:24] = wdata[7:0];
                    default: st_word = word;
                endcase
                ld_word = is_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            SIZE_HALF: begin
                if (lane[1]) st_word[31:16] = wdata[15:0];
                else         st_word[15:0]  = wdata[15:0];
                ld_word = is_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            default: begin
                st_word = wdata;
                ld_word = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// One request at a time; sub-word stores are read-modify-write; misaligned
// or illegal-size requests answer with an error and never touch memory.
// All outputs are registered from the next-state decode.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [31:0]       mem_pc,
    input  logic [DATA_W-1:0] mem_rdata
);

    mau_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] word_q, word_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              bad_req;
    logic [DATA_W-1:0] lane_st_word;
    logic [DATA_W-1:0] lane_ld_word;

    // The lane logic sees the word being captured this cycle (mem_rdata in READ)
    mau_lane u_lane (
        .word        (word_d),
        .lane        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .st_word     (lane_st_word),
        .ld_word     (lane_ld_word)
    );

    // Next-state, request latch and registered-output decode
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pc_d         = pc_q;
        word_d       = word_q;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_wdata_d  = '0;
        bad_req      = (req_size == SIZE_RSVD)
                    || ((req_size == SIZE_HALF) && req_addr[0])
                    || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    if (bad_req) begin
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                    end else if (req_we && (req_size == SIZE_WORD)) begin
                        state_d     = ST_WRITE;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                word_d = mem_rdata;
                if (we_q) begin
                    state_d     = ST_WRITE;
                    mem_wdata_d = lane_st_word;
                end else begin
                    state_d      = ST_RESP;
                    resp_rdata_d = lane_ld_word;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        mem_read_d   = (state_d == ST_READ);
        mem_write_d  = (state_d == ST_WRITE);
        mem_addr_d   = (mem_read_d || mem_write_d) ? (addr_d & ADDR_W'(WORD_ALIGN_MASK)) : '0;
    end

    // State, latched request and registered outputs; reset aborts any transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pc_q         <= '0;
            word_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
            word_q       <= word_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_pc     = pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-timeline reference
// model, a word memory, and hand-computed literal expectations.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_pc       (req_pc),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_pc       (mem_pc),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on posedge
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic        busy = 1'b0;
    logic        was_busy;
    int          k = 0;
    int          t_lat = 0;
    logic        t_err, t_read, t_wr;
    logic [31:0] t_al, t_rdata, t_wword, m_pc;
    logic [31:0] w;
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic        e_rd, e_wr, e_rv;
    logic [31:0] e_addr;

    initial m_pc = 32'h0;

    // Every negedge: compare DUT outputs with the timeline expected for the current cycle
    always @(negedge clk) begin
        if (!reset) begin
            busy = 1'b0;
            k    = 0;
            m_pc = 32'h0;
            check("rst_ready", {31'h0, req_ready}, 32'h1);
            check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
            check("rst_resp_err", {31'h0, resp_err}, 32'h0);
            check("rst_resp_rdata", resp_rdata, 32'h0);
            check("rst_mem_read", {31'h0, mem_read}, 32'h0);
            check("rst_mem_write", {31'h0, mem_write}, 32'h0);
            check("rst_mem_addr", mem_addr, 32'h0);
            check("rst_mem_wdata", mem_wdata, 32'h0);
            check("rst_mem_pc", mem_pc, 32'h0);
        end else begin
            was_busy = busy;
            if (busy) k++;
            e_rd   = was_busy && t_read && (k == 1);
            e_wr   = was_busy && t_wr && (k == t_lat - 1);
            e_rv   = was_busy && (k == t_lat);
            e_addr = (e_rd || e_wr) ? t_al : 32'h0;
            check("cyc_ready", {31'h0, req_ready}, {31'h0, !was_busy});
            check("cyc_resp_valid", {31'h0, resp_valid}, {31'h0, e_rv});
            check("cyc_resp_err", {31'h0, resp_err}, {31'h0, e_rv && t_err});
            check("cyc_resp_rdata", resp_rdata, e_rv ? t_rdata : 32'h0);
            check("cyc_mem_read", {31'h0, mem_read}, {31'h0, e_rd});
            check("cyc_mem_write", {31'h0, mem_write}, {31'h0, e_wr});
            check("cyc_mem_addr", mem_addr, e_addr);
            check("cyc_mem_pc", mem_pc, m_pc);
            if (e_wr) begin
                check("cyc_mem_wdata", mem_wdata, t_wword);
                ref_mem[t_al[9:2]] = t_wword;
            end
            if (was_busy && (k == t_lat)) busy = 1'b0;
            if (!was_busy && req_valid) begin
                t_err = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0])
                     || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
                t_al   = {req_addr[31:2], 2'b00};
                t_read = !t_err && !(req_we && req_size == 2'd2);
                t_wr   = !t_err && req_we;
                t_lat  = t_err ? 1 : (req_we && req_size != 2'd2) ? 3 : 2;
                w      = ref_mem[req_addr[9:2]];
                sh     = {req_addr[1:0], 3'b000};
                b      = 8'(w >> sh);
                h      = req_addr[1] ? w[31:16] : w[15:0];
                t_rdata = 32'h0;
                t_wword = req_wdata;
                if (!t_err && !req_we) begin
                    if (req_size == 2'd0)      t_rdata = req_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
                    else if (req_size == 2'd1) t_rdata = req_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
                    else                       t_rdata = w;
                end
                if (req_size == 2'd0)
                    t_wword = (w & ~(32'hFF << sh)) | ({24'h0, req_wdata[7:0]} << sh);
                else if (req_size == 2'd1)
                    t_wword = req_addr[1] ? {req_wdata[15:0], w[15:0]} : {w[31:16], req_wdata[15:0]};
                m_pc = req_pc;
                busy = 1'b1;
                k    = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem[a[9:2]]     = v;
        ref_mem[a[9:2]] = v;
    endtask

    // Issue one request from an idle cycle (called at posedge+1), wait for the response
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int wr_k, output logic saw_rw);
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_pc = pc; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rd = 32'h0; er = 1'b0; lat = -1; wr_k = -1; saw_rw = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (mem_read || mem_write) saw_rw = 1'b1;
            if (mem_write && wr_k < 0) wr_k = n;
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) check("resp_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
    endtask

    logic [31:0] rd, rd_a, rd_b;
    logic        er, rw;
    int          lat, wk, n_resp, first_n, second_n;

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
        for (int i = 0; i < 256; i++) preload(32'(i * 4), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'h0, req_ready}, 32'h1);
        check("reset_mem_pc", mem_pc, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // word store then load
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 32'h100, rd, er, lat, wk, rw);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_write_cycle", 32'(wk), 32'd1);
        check("sw_mem", mem[4], 32'h12345678);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h104, rd, er, lat, wk, rw);
        check("lw_data", rd, 32'h12345678);
        check("lw_err", {31'h0, er}, 32'h0);
        check("lw_lat", 32'(lat), 32'd2);

        // sign/zero extended sub-word loads
        preload(32'h20, 32'h80FF7F01);
        do_req(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 32'h108, rd, er, lat, wk, rw);
        check("lb_22", rd, 32'hFFFFFFFF);
        do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 32'h10C, rd, er, lat, wk, rw);
        check("lbu_23", rd, 32'h00000080);
        do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'h110, rd, er, lat, wk, rw);
        check("lb_23", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 32'h114, rd, er, lat, wk, rw);
        check("lh_20", rd, 32'h00007F01);
        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h118, rd, er, lat, wk, rw);
        check("lhu_22", rd, 32'h000080FF);
        do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h11C, rd, er, lat, wk, rw);
        check("lh_22", rd, 32'hFFFF80FF);

        // read-modify-write sub-word stores
        preload(32'h20, 32'hAABBCCDD);
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'hDEAD1234, 32'h120, rd, er, lat, wk, rw);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_write_cycle", 32'(wk), 32'd2);
        check("sh_mem", mem[8], 32'h1234CCDD);
        check("sh_rdata", rd, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'hCAFE0099, 32'h124, rd, er, lat, wk, rw);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_mem", mem[8], 32'h123499DD);

        // misaligned and illegal size
        do_req(1'b0, 2'd2, 1'b0, 32'h21, 32'h0, 32'h128, rd, er, lat, wk, rw);
        check("lw_mis_err", {31'h0, er}, 32'h1);
        check("lw_mis_lat", 32'(lat), 32'd1);
        check("lw_mis_rw", {31'h0, rw}, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFF, 32'h12C, rd, er, lat, wk, rw);
        check("sh_mis_err", {31'h0, er}, 32'h1);
        check("sh_mis_lat", 32'(lat), 32'd1);
        check("sh_mis_rw", {31'h0, rw}, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h130, rd, er, lat, wk, rw);
        check("sz3_err", {31'h0, er}, 32'h1);
        check("sz3_lat", 32'(lat), 32'd1);
        check("sz3_rdata", rd, 32'h0);
        check("sz3_rw", {31'h0, rw}, 32'h0);

        // reset while a sub-word store is in READ
        preload(32'h30, 32'h11223344);
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h31; req_wdata = 32'h55; req_pc = 32'h140; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_read", {31'h0, mem_read}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        check("abort_mem_read", {31'h0, mem_read}, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_mem_pc", mem_pc, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        rw = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_write) rw = 1'b1;
        end
        check("abort_no_write", {31'h0, rw}, 32'h0);
        check("abort_mem_word", mem[12], 32'h11223344);

        // back-to-back with req_valid held
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0; req_pc = 32'h200; req_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_pc_a", mem_pc, 32'h200);
        check("b2b_busy_a", {31'h0, req_ready}, 32'h0);
        req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h21; req_pc = 32'h204;
        n_resp = 0; first_n = -1; second_n = -1; rd_a = 32'h0; rd_b = 32'h0;
        for (int n = 1; n <= 15; n++) begin
            if (resp_valid) begin
                if (n_resp == 0) begin first_n = n; rd_a = resp_rdata; end
                else begin second_n = n; rd_b = resp_rdata; end
                n_resp++;
            end
            if (n_resp == 1 && !resp_valid && !req_ready && req_valid) begin
                req_valid = 1'b0;
                check("b2b_pc_b", mem_pc, 32'h204);
            end
            if (n_resp == 2) break;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("b2b_first_lat", 32'(first_n), 32'd2);
        check("b2b_second_at", 32'(second_n), 32'd5);
        check("b2b_rd_a", rd_a, 32'h12345678);
        check("b2b_rd_b", rd_b, 32'h00000099);
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
